// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch types, instruction field positions and vectors; honours PC_MISALIGN_TRAP_EN
package cpu_pkg;

  // Fetch FSM states; TRAP exists only when misaligned jr targets raise a trap
`ifdef PC_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_TRAP = 2'd2
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1
  } fetch_state_e;
`endif

  // Jump index field of a J-type instruction
  localparam int JIDX_MSB = 25;
  localparam int JIDX_LSB = 0;
  localparam int JIDX_W   = JIDX_MSB - JIDX_LSB + 1;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0180;

  // j/jal target: keep the region bits of pc+4, splice in the word index
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus_4,
                                              input logic [JIDX_W-1:0] index);
    return {pc_plus_4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - instruction-memory request/response bus
interface ifetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational next-PC priority mux (jr > j/jal > taken branch > pc+4)
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0]       pc,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic [31:0]       addr_result,
  input  logic              zero,
  input  logic [31:0]       read_data_1,
  input  logic              branch,
  input  logic              nbranch,
  input  logic              jmp,
  input  logic              jal,
  input  logic              jr,
  output logic [31:0]       pc_plus_4,
  output logic [31:0]       next_pc
);

  logic take_branch;

  // Branch targets arrive as word addresses, so the top two bits drop out
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_result[31:30];

  // 32-bit add wraps naturally at the top of the address space
  assign pc_plus_4   = pc + 32'd4;
  assign take_branch = (branch & zero) | (nbranch & ~zero);

  // Priority select of the successor PC
  always_comb begin
    next_pc = pc_plus_4;
    if (jr) begin
      next_pc = read_data_1;
    end else if (jmp || jal) begin
      next_pc = jump_target(pc_plus_4, jump_index);
    end else if (take_branch) begin
      next_pc = {addr_result[29:0], 2'b00};
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage with PC, imem handshake and held instruction; optional PC_MISALIGN_TRAP_EN
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic                 clock,
  input  logic                 reset,
  ifetch_unit_if.master        imem,
  output logic [31:0]          Instruction,
  output logic                 inst_valid,
  input  logic                 stall,
  input  logic [31:0]          Addr_Result,
  input  logic                 Zero,
  input  logic [31:0]          Read_data_1,
  input  logic                 Branch,
  input  logic                 nBranch,
  input  logic                 Jmp,
  input  logic                 Jal,
  input  logic                 Jr,
  output logic [31:0]          branch_base_addr,
  output logic [31:0]          link_addr,
`ifdef PC_MISALIGN_TRAP_EN
  output logic                 trap,
`endif
  output logic [31:0]          pc
);

  fetch_state_e state, state_n;
  logic [31:0]  pc_plus_4;
  logic [31:0]  sel_next_pc;
  logic [31:0]  commit_pc;
  logic         commit;
  logic         fetch_done;

  next_pc_sel u_next_pc_sel (
    .pc          (pc),
    .jump_index  (Instruction[JIDX_MSB:JIDX_LSB]),
    .addr_result (Addr_Result),
    .zero        (Zero),
    .read_data_1 (Read_data_1),
    .branch      (Branch),
    .nbranch     (nBranch),
    .jmp         (Jmp),
    .jal         (Jal),
    .jr          (Jr),
    .pc_plus_4   (pc_plus_4),
    .next_pc     (sel_next_pc)
  );

  assign fetch_done       = (state == S_REQ) && imem.ready;
  assign commit           = (state == S_HOLD) && !stall;
  assign imem.addr        = pc;
  assign branch_base_addr = pc_plus_4;
  assign link_addr        = pc_plus_4;

`ifdef PC_MISALIGN_TRAP_EN
  logic jr_misalign;
  assign jr_misalign = Jr && (Read_data_1[1:0] != 2'b00);
  assign commit_pc   = jr_misalign ? EXC_VECTOR : sel_next_pc;
`else
  // Without the trap the exception vector has no consumer
  logic unused_exc_vector;
  assign unused_exc_vector = ^EXC_VECTOR;
  // jr targets are silently word-aligned
  assign commit_pc = Jr ? {sel_next_pc[31:2], 2'b00} : sel_next_pc;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_REQ;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: fetch until ready, hold until committed
  always_comb begin
    state_n = state;
    case (state)
      S_REQ:  if (imem.ready) state_n = S_HOLD;
      S_HOLD: begin
        if (!stall) begin
`ifdef PC_MISALIGN_TRAP_EN
          state_n = jr_misalign ? S_TRAP : S_REQ;
`else
          state_n = S_REQ;
`endif
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      S_TRAP: state_n = S_REQ;
`endif
      default: state_n = S_REQ;
    endcase
  end

  // Outputs decoded from state; forced quiet while reset is asserted
  always_comb begin
    imem.req   = 1'b0;
    inst_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    trap       = 1'b0;
`endif
    if (!reset) begin
      case (state)
        S_REQ:  imem.req   = 1'b1;
        S_HOLD: inst_valid = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
        S_TRAP: trap       = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // PC and held instruction; a ready coinciding with reset is dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      Instruction <= '0;
    end else begin
      if (fetch_done) Instruction <= imem.rdata;
      if (commit)     pc          <= commit_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit; honours PC_MISALIGN_TRAP_EN
module tb_ifetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [31:0] Instruction;
  logic        inst_valid;
  logic        stall;
  logic [31:0] Addr_Result;
  logic        Zero;
  logic [31:0] Read_data_1;
  logic        Branch, nBranch, Jmp, Jal, Jr;
  logic [31:0] branch_base_addr, link_addr, pc;
`ifdef PC_MISALIGN_TRAP_EN
  logic        trap;
`endif

  ifetch_unit_if imem_bus ();

  ifetch_unit dut (
    .clock            (clock),
    .reset            (reset),
    .imem             (imem_bus.master),
    .Instruction      (Instruction),
    .inst_valid       (inst_valid),
    .stall            (stall),
    .Addr_Result      (Addr_Result),
    .Zero             (Zero),
    .Read_data_1      (Read_data_1),
    .Branch           (Branch),
    .nBranch          (nBranch),
    .Jmp              (Jmp),
    .Jal              (Jal),
    .Jr               (Jr),
    .branch_base_addr (branch_base_addr),
    .link_addr        (link_addr),
`ifdef PC_MISALIGN_TRAP_EN
    .trap             (trap),
`endif
    .pc               (pc)
  );

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_rise = 0;
  logic        period_chk = 1'b0;
  int          resp_mode = 0;   // 0 idle, 1 zero-wait memory, 2 forced ready with force_data
  logic [31:0] force_data = 32'h0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h0C00_0100;
    return {8'h20, a[23:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: drives just after each falling edge
  initial begin
    imem_bus.ready = 1'b0;
    imem_bus.rdata = 32'h0;
    forever begin
      @(negedge clock);
      #1;
      case (resp_mode)
        1: begin
          imem_bus.ready = imem_bus.req;
          imem_bus.rdata = mem(imem_bus.addr);
        end
        2: begin
          imem_bus.ready = 1'b1;
          imem_bus.rdata = force_data;
        end
        default: begin
          imem_bus.ready = 1'b0;
          imem_bus.rdata = 32'h0;
        end
      endcase
    end
  end

  // Monitor: each newly presented instruction is matched against the scoreboard
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (inst_valid === 1'b1 && !prev_valid) begin
        if (period_chk) check("valid_period", cyc - last_rise, 32'd2);
        last_rise = cyc;
        check("expected_pending", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("fetch_pc", pc, e.pc);
          check("fetch_instr", Instruction, e.instr);
          check("link_addr", link_addr, e.pc + 32'd4);
          check("branch_base_addr", branch_base_addr, e.pc + 32'd4);
        end
      end
      prev_valid = (inst_valid === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_ctrl();
    Jr = 0; Jmp = 0; Jal = 0; Branch = 0; nBranch = 0; Zero = 0;
    Addr_Result = 32'h0; Read_data_1 = 32'h0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (inst_valid === 1'b1) break;
    end
    check("inst_valid_wait", {31'b0, inst_valid}, 32'd1);
  endtask

  // Commit the held instruction with the given controls; expect a fetch at nxt
  task automatic commit(input logic jr_i, input logic jmp_i, input logic jal_i,
                        input logic br_i, input logic nbr_i, input logic zero_i,
                        input logic [31:0] ares, input logic [31:0] rd1,
                        input logic [31:0] nxt);
    wait_valid();
    Jr = jr_i; Jmp = jmp_i; Jal = jal_i; Branch = br_i; nBranch = nbr_i; Zero = zero_i;
    Addr_Result = ares; Read_data_1 = rd1;
    exp_q.push_back('{nxt, mem(nxt)});
    @(posedge clock);
    #1;
    // noise during REQ must be ignored
    Jr = 1; Jmp = 1; Read_data_1 = 32'hBAD0_0000;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    clear_ctrl();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", Instruction, 32'h0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_imem_req", {31'b0, imem_bus.req}, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
    check("rst_trap", {31'b0, trap}, 32'd0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    resp_mode = 1;
    exp_q.push_back('{32'h0, mem(32'h0)});
    @(negedge clock);
    check("first_req", {31'b0, imem_bus.req}, 32'd1);
    check("first_addr", imem_bus.addr, 32'h0);

    commit(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4);
    period_chk = 1'b1;
    commit(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8);
    commit(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hC);
    commit(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h10);
    period_chk = 1'b0;
    commit(0, 0, 0, 1, 0, 1, 32'h20, 32'h0, 32'h80);
    commit(1, 0, 0, 0, 0, 0, 32'h0, 32'h10, 32'h10);
    commit(0, 0, 0, 1, 0, 0, 32'h20, 32'h0, 32'h14);
    commit(0, 0, 0, 0, 1, 0, 32'h30, 32'h0, 32'hC0);
    commit(1, 1, 0, 0, 0, 0, 32'h0, 32'h0040_0000, 32'h0040_0000);
    commit(0, 0, 1, 1, 0, 1, 32'h5, 32'h0, 32'h400);

    // Stall five cycles in HOLD with a stray ready and jump asserted
    wait_valid();
    clear_ctrl();
    Jmp = 1;
    stall = 1'b1;
    force_data = 32'hFFFF_FFFF;
    resp_mode = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_pc", pc, 32'h400);
      check("stall_instr", Instruction, mem(32'h400));
      check("stall_imem_req", {31'b0, imem_bus.req}, 32'd0);
      check("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
    end
    clear_ctrl();
    stall = 1'b0;
    resp_mode = 1;
    exp_q.push_back('{32'h404, mem(32'h404)});
    @(posedge clock);
    #1;
    check("release_pc", pc, 32'h404);

    commit(1, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    commit(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);

    // Misaligned jr at pc 0
    wait_valid();
    clear_ctrl();
    resp_mode = 0;
    Jr = 1;
    Read_data_1 = 32'h0000_0102;
    @(posedge clock);
    #1;
    clear_ctrl();
    @(negedge clock);
`ifdef PC_MISALIGN_TRAP_EN
    check("trap_pulse", {31'b0, trap}, 32'd1);
    check("trap_pc", pc, 32'h180);
    @(negedge clock);
    check("trap_end", {31'b0, trap}, 32'd0);
    check("trap_then_req", {31'b0, imem_bus.req}, 32'd1);
`else
    check("jr_align_pc", pc, 32'h100);
    check("jr_align_addr", imem_bus.addr, 32'h100);
    check("jr_align_req", {31'b0, imem_bus.req}, 32'd1);
`endif

    // Reset in REQ with a coincident ready
    force_data = 32'hDEAD_BEEF;
    resp_mode = 2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    resp_mode = 0;
    @(negedge clock);
    check("rst2_instr", Instruction, 32'h0);
    check("rst2_pc", pc, 32'h0);
    check("rst2_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst2_imem_req", {31'b0, imem_bus.req}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    resp_mode = 1;
    exp_q.push_back('{32'h0, mem(32'h0)});
    @(negedge clock);
    check("restart_req", {31'b0, imem_bus.req}, 32'd1);
    check("restart_addr", imem_bus.addr, 32'h0);
    commit(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4);

    wait_valid();
    clear_ctrl();
    stall = 1'b1;
    repeat (3) @(negedge clock);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage of the single-cycle MIPS core, sitting directly upstream of the execute unit. Holds the PC, fetches instructions from instruction memory over a ready/valid handshake, and presents each instruction to decode/execute until the core commits it. The next PC is selected from the execute unit's `Addr_Result`/`Zero`, the jump field, or `Read_data_1` for `jr`.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address fetched first after reset.
- `EXC_VECTOR`, default 32'h0000_0180: trap target; used only when `PC_MISALIGN_TRAP_EN` is defined.
- `clock` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: fetch request, held high until `imem_ready`.
- `imem_addr` out 32: byte address of the requested word, always `pc`.
- `imem_ready` in 1: `imem_rdata` valid this cycle.
- `imem_rdata` in 32: fetched instruction.
- `Instruction` out 32: held instruction to decode.
- `inst_valid` out 1: `Instruction` is valid.
- `stall` in 1: downstream hold; the instruction is not committed this cycle.
- `Addr_Result` in 32: branch target word address from execute.
- `Zero` in 1: execute zero flag.
- `Read_data_1` in 32: register rs, the `jr` target.
- `Branch`, `nBranch`, `Jmp`, `Jal`, `Jr` in 1 each: decoded control for the held instruction.
- `branch_base_addr` out 32: `pc + 4`, feeds execute `PC_plus_4`.
- `link_addr` out 32: `pc + 4`, written to $31 on `jal`.
- `pc` out 32: current PC.
- `trap` out 1: one-cycle pulse on a misaligned `jr`; only when `PC_MISALIGN_TRAP_EN` is defined.

## Operation
- FSM states are REQ, HOLD and, with `PC_MISALIGN_TRAP_EN`, TRAP.
- REQ: `imem_req=1`. On `imem_ready`, latch `imem_rdata` into `Instruction` and go to HOLD.
- HOLD: `inst_valid=1`, `imem_req=0`. A commit is HOLD with `stall=0`; on commit, `pc <= next_pc` and go to REQ. With `stall=1`, every register holds.
- `next_pc` priority, highest first:
  - `Jr`: `Read_data_1`.
  - `Jmp` or `Jal`: `{pc_plus_4[31:28], Instruction[25:0], 2'b00}`.
  - `(Branch & Zero) | (nBranch & ~Zero)`: `{Addr_Result[29:0], 2'b00}`.
  - Otherwise: `pc + 4`.
- All adds are 32-bit and wrap modulo 2^32; `pc = 32'hFFFF_FFFC` gives `pc + 4 = 0`.
- Control inputs are sampled only in HOLD; they are ignored in REQ.

## Timing
- Reset values: `pc=RESET_PC`, state REQ, `Instruction=0`, `inst_valid=0`, `imem_req=0` in the reset cycle, `trap=0`.
- First `imem_req=1` is the cycle after `reset` deasserts.
- Fetch latency: `inst_valid` rises the cycle after `imem_ready`. Zero-wait memory gives one instruction every 2 cycles.
- `imem_ready` is ignored outside REQ.
- `reset` during REQ or HOLD aborts the operation. A late `imem_ready` in the reset cycle is discarded.
- `branch_base_addr` and `link_addr` are combinational from `pc`. They are stable for the whole of HOLD.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined:
  - A commit with `Jr` and `Read_data_1[1:0]!=0` sets `pc <= EXC_VECTOR` and enters TRAP instead of REQ.
  - TRAP lasts one cycle with `trap=1`, then goes to REQ.
- `PC_MISALIGN_TRAP_EN` not defined:
  - No TRAP state, `trap` port absent.
  - `jr` targets are force-aligned: `pc <= {Read_data_1[31:2], 2'b00}`.

## Structure
- Shared package `cpu_pkg` holds:
  - the FSM state enum;
  - the instruction field positions (`[25:0]` jump index);
  - the default reset and exception vector constants.
- One sub-module, `next_pc_sel`: purely combinational next-PC priority mux, reusable by a later pipelined fetch.

## Test plan
- Reset, then `imem_ready` every cycle, no stall, no control → `pc` steps 0, 4, 8; `inst_valid` pulses every 2nd cycle.
- At `pc=0x10`, `Branch=1`, `Zero=1`, `Addr_Result=0x20` → next fetch `imem_addr=0x80`. Repeat with `Zero=0` → `0x14`.
- At `pc=0x0040_0000`, `Jal=1`, `Instruction[25:0]=0x100` → `link_addr=0x0040_0004`, next `pc=0x0000_0400`.
- `stall=1` for 5 cycles in HOLD → `pc` and `Instruction` unchanged, `imem_req=0`. Release → single advance.
- `Jr`, `Read_data_1=0x0000_0102`:
  - with macro → `trap` pulse, `pc=0x180`;
  - without macro → `pc=0x100`.
- `reset` asserted mid-REQ with `imem_ready` the same cycle → `Instruction=0`, `pc=RESET_PC`; fetch restarts cleanly.
